fp_div: RTL and testbench
=========================

# fp_div

Iterative IEEE-754-style floating-point divider, parameterised on mantissa/exponent width. It computes Q = A / B using a restoring shift-subtract loop that produces one quotient bit per cycle. It sits in the FP ALU beside the multiplier as the inverse operation and uses the same operand encoding, flag set and `enable`/`load`/`done` handshake, so the ALU front-end drives both blocks identically. Rounding is truncation and subnormals are flushed to zero, both matching the multiplier.

## Interface
- `Mantissa_Size`, 23, stored fraction bits
- `Exponent_Size`, 8, exponent bits
- `Bias`, 127, exponent bias
- `N`, `Mantissa_Size+Exponent_Size`, MSB index of the operand/result word
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `enable`  in  1  clock enable; low freezes all state and outputs
- `load`  in  1  with `enable`: capture `A`,`B` and start a divide
- `A`  in  N+1  dividend {sign, exponent, fraction}
- `B`  in  N+1  divisor
- `result`  out  N+1  quotient, held until next accepted load
- `done`  out  1  result and flags valid
- `busy`  out  1  divide in progress
- `zero`, `overflow`, `underflow`, `NAN`, `div_by_zero`  out  1 each  status flags

## Operation
- States: IDLE, DIVIDE, NORM, DONE.
- Reset (async) → IDLE. All outputs are 0, including `result`.
- Accepted load = `enable && load` at a clock edge, in any state. An accepted load aborts any divide in progress.
- On an accepted load:
  - Clear all flags and `done`.
  - Latch SA/SB, EA/EB, MA={1,fracA}, MB={1,fracB}. Set SR=SA^SB.
- Special-case priority, resolved in the load cycle. Next state is DONE.
  1. NaN if either operand has exp all-ones with fraction≠0, or 0/0, or inf/inf. Action: `NAN`=1, result = {0, all-ones exp, 1 then zeros}.
  2. A=inf, B finite. Action: `overflow`=1, result = ±inf.
  3. B=0, A finite nonzero. Action: `div_by_zero`=1, `overflow`=1, result = ±inf.
  4. A=0 or B=inf. Action: `zero`=1, result = {SR, 0…}.
  - "Zero" means exp==0; any fraction bits are flushed.
- Otherwise:
  - `busy`=1 and go to DIVIDE.
  - Remainder R ← MA. Width is Mantissa_Size+2.
  - Signed exponent E ← EA − EB + Bias. Width is Exponent_Size+2.
- DIVIDE runs for exactly Mantissa_Size+2 cycles. Each cycle:
  - If R ≥ MB: q=1, R ← R−MB. Else q=0.
  - Shift q into Q (width Mantissa_Size+2, MSB first). Then R ← R<<1.
- NORM, one cycle:
  - If Q[MSB]=1: frac = Q[Mantissa_Size:1], E unchanged.
  - Else: frac = Q[Mantissa_Size-1:0], E ← E−1.
  - If E ≤ 0: `underflow`=1, `zero`=1, result = {SR, 0…}.
  - Else if E ≥ all-ones: `overflow`=1, result = {SR, all-ones, 0…}.
  - Else: result = {SR, E[Exponent_Size-1:0], frac}.
- DONE: `done`=1, `busy`=0. Hold there until the next accepted load.

## Timing
- Load at edge t:
  - Special case: `done` is high after edge t+1.
  - Normal case: `busy` is high after edge t, and `done` is high after edge t+Mantissa_Size+3. That is 26 cycles for the defaults.
- `done` and `busy` are never high together.
- `result` and flags change only at the NORM→DONE edge or at the special-case DONE edge.
- `result` and flags stay stable while `done`=1.
- `enable` low mid-divide stalls the iteration count without losing state.
- `load` while `enable` is low is ignored.
- `rst` mid-divide forces IDLE immediately and zeroes all outputs. It does not wait for a clock.

## Test plan
- 0x40C00000 / 0x40000000 → result 0x40400000, done after 26 cycles, all flags 0. Also 0xBFC00000 / 0x3F000000 → 0xC0400000.
- 0x3F800000 / 0x40400000 → 0x3EAAAAAA (truncated 1/3). This exercises the Q[MSB]=0 normalize path.
- 0x3F800000 / 0x00000000 → 0x7F800000, `div_by_zero`=1, `overflow`=1, done 1 cycle after load. Also 0 / 0 → 0x7FC00000, `NAN`=1, `div_by_zero`=0.
- 0x7F000000 / 0x3E800000 → 0x7F800000, `overflow`=1. Also 0x00800000 / 0x40000000 → 0x00000000, `underflow`=1, `zero`=1.
- Restart mid-divide: load 6/2, then at cycle 10 load 0x41200000 / 0x40A00000 → 0x40000000 only, done 26 cycles after the second load.
- Async reset at cycle 12 of a divide → `busy`/`done`/`result`/flags are 0 before the next edge. Toggling `enable` low for 5 cycles mid-divide → done is delayed by exactly 5 cycles and the result is correct.

Source files
------------

// File: rtl/fp_div_if.sv
// Handshake and data bundle shared by the FP divider and its front-end.
// N is the MSB index of the {sign, exponent, fraction} word.
interface fp_div_if #(
    parameter int N = 31
);
    logic       enable;
    logic       load;
    logic [N:0] A;
    logic [N:0] B;
    logic [N:0] result;
    logic       done;
    logic       busy;
    logic       zero;
    logic       overflow;
    logic       underflow;
    logic       NAN;
    logic       div_by_zero;

    modport master (
        output enable, load, A, B,
        input  result, done, busy, zero, overflow, underflow, NAN, div_by_zero
    );

    modport slave (
        input  enable, load, A, B,
        output result, done, busy, zero, overflow, underflow, NAN, div_by_zero
    );
endinterface

// File: rtl/fp_div.sv
// Iterative restoring floating-point divider: one quotient bit per cycle,
// truncating, subnormals flushed to zero, same handshake as the FP multiplier.
module fp_div #(
    parameter int Mantissa_Size = 23,
    parameter int Exponent_Size = 8,
    parameter int Bias          = 127,
    parameter int N             = Mantissa_Size + Exponent_Size
) (
    input  logic     clk,
    input  logic     rst,
    fp_div_if.slave  bus
);
    localparam int QW        = Mantissa_Size + 2;
    localparam int EW        = Exponent_Size + 2;
    localparam int CW        = $clog2(QW + 1);
    localparam int EXP_ONES  = (1 << Exponent_Size) - 1;

    localparam logic [EW-1:0] BIAS_EXT = EW'(Bias);
    localparam logic [EW-1:0] ONE_EXT  = EW'(1);
    localparam logic [EW-2:0] TOP_EXP  = EXP_ONES[EW-2:0];
    localparam logic [CW-1:0] LAST_CNT = CW'(QW - 1);

    localparam logic [2:0] K_NONE = 3'd0;
    localparam logic [2:0] K_NAN  = 3'd1;
    localparam logic [2:0] K_INF  = 3'd2;
    localparam logic [2:0] K_DIV0 = 3'd3;
    localparam logic [2:0] K_ZERO = 3'd4;

    typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;

    state_t state_reg, state_next;

    logic                     sr_reg;
    logic [EW-1:0]            e_reg;
    logic [Mantissa_Size:0]   mb_reg;
    logic [QW-1:0]            r_reg;
    logic [QW-1:0]            q_reg;
    logic [CW-1:0]            cnt_reg;
    logic [2:0]               kind_reg;
    logic [N:0]               result_reg;
    logic                     done_reg, busy_reg;
    logic                     zero_reg, overflow_reg, underflow_reg, nan_reg, div0_reg;

    // Operand classification; the priority order decides which flag wins.
    function automatic logic [2:0] classify(
        input logic [Exponent_Size-1:0] ea,
        input logic [Mantissa_Size-1:0] fa,
        input logic [Exponent_Size-1:0] eb,
        input logic [Mantissa_Size-1:0] fb
    );
        logic a_max, b_max, a_zero, b_zero;
        a_max  = &ea;
        b_max  = &eb;
        a_zero = ~|ea;
        b_zero = ~|eb;
        if ((a_max && |fa) || (b_max && |fb) || (a_zero && b_zero) || (a_max && b_max))
            return K_NAN;
        else if (a_max)
            return K_INF;
        else if (b_zero && !a_zero)
            return K_DIV0;
        else if (a_zero || b_max)
            return K_ZERO;
        else
            return K_NONE;
    endfunction

    logic                     a_sign, b_sign;
    logic [Exponent_Size-1:0] a_exp, b_exp;
    logic [Mantissa_Size-1:0] a_frac, b_frac;
    logic [2:0]               load_kind;
    logic [EW-1:0]            e_load;
    logic                     accept;

    assign a_sign    = bus.A[N];
    assign b_sign    = bus.B[N];
    assign a_exp     = bus.A[N-1:Mantissa_Size];
    assign b_exp     = bus.B[N-1:Mantissa_Size];
    assign a_frac    = bus.A[Mantissa_Size-1:0];
    assign b_frac    = bus.B[Mantissa_Size-1:0];
    assign load_kind = classify(a_exp, a_frac, b_exp, b_frac);
    assign e_load    = {2'b00, a_exp} - {2'b00, b_exp} + BIAS_EXT;
    assign accept    = bus.enable && bus.load;

    // One restoring step: subtract when the divisor fits, then shift.
    logic          q_bit;
    logic [QW-1:0] r_sub;
    assign q_bit = (r_reg >= {1'b0, mb_reg});
    assign r_sub = q_bit ? (r_reg - {1'b0, mb_reg}) : r_reg;

    logic [Mantissa_Size-1:0] norm_frac;
    logic [EW-1:0]            norm_exp;
    logic                     norm_under, norm_over;
    assign norm_frac  = q_reg[QW-1] ? q_reg[Mantissa_Size:1] : q_reg[Mantissa_Size-1:0];
    assign norm_exp   = q_reg[QW-1] ? e_reg : (e_reg - ONE_EXT);
    assign norm_under = norm_exp[EW-1] || (norm_exp == '0);
    assign norm_over  = !norm_exp[EW-1] && (norm_exp[EW-2:0] >= TOP_EXP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (bus.enable) begin
            if (bus.load) begin
                state_next = (load_kind != K_NONE) ? DONE : DIVIDE;
            end else begin
                case (state_reg)
                    DIVIDE:  if (cnt_reg == LAST_CNT) state_next = NORM;
                    NORM:    state_next = DONE;
                    default: state_next = state_reg;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_reg        <= 1'b0;
            e_reg         <= '0;
            mb_reg        <= '0;
            r_reg         <= '0;
            q_reg         <= '0;
            cnt_reg       <= '0;
            kind_reg      <= K_NONE;
            result_reg    <= '0;
            done_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            zero_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
            nan_reg       <= 1'b0;
            div0_reg      <= 1'b0;
        end else if (accept) begin
            sr_reg        <= a_sign ^ b_sign;
            e_reg         <= e_load;
            mb_reg        <= {1'b1, b_frac};
            r_reg         <= {2'b01, a_frac};
            q_reg         <= '0;
            cnt_reg       <= '0;
            kind_reg      <= load_kind;
            done_reg      <= 1'b0;
            busy_reg      <= (load_kind == K_NONE);
            zero_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
            nan_reg       <= 1'b0;
            div0_reg      <= 1'b0;
        end else if (bus.enable) begin
            case (state_reg)
                DIVIDE: begin
                    q_reg   <= {q_reg[QW-2:0], q_bit};
                    r_reg   <= r_sub << 1;
                    cnt_reg <= cnt_reg + 1'b1;
                end
                NORM: begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                    if (norm_under) begin
                        underflow_reg <= 1'b1;
                        zero_reg      <= 1'b1;
                        result_reg    <= {sr_reg, {N{1'b0}}};
                    end else if (norm_over) begin
                        overflow_reg <= 1'b1;
                        result_reg   <= {sr_reg, {Exponent_Size{1'b1}}, {Mantissa_Size{1'b0}}};
                    end else begin
                        result_reg <= {sr_reg, norm_exp[Exponent_Size-1:0], norm_frac};
                    end
                end
                DONE: begin
                    // Special cases land here straight from the load with done still low.
                    if (!done_reg) begin
                        done_reg <= 1'b1;
                        case (kind_reg)
                            K_NAN: begin
                                nan_reg    <= 1'b1;
                                result_reg <= {1'b0, {Exponent_Size{1'b1}}, 1'b1, {(Mantissa_Size-1){1'b0}}};
                            end
                            K_INF: begin
                                overflow_reg <= 1'b1;
                                result_reg   <= {sr_reg, {Exponent_Size{1'b1}}, {Mantissa_Size{1'b0}}};
                            end
                            K_DIV0: begin
                                div0_reg     <= 1'b1;
                                overflow_reg <= 1'b1;
                                result_reg   <= {sr_reg, {Exponent_Size{1'b1}}, {Mantissa_Size{1'b0}}};
                            end
                            default: begin
                                zero_reg   <= 1'b1;
                                result_reg <= {sr_reg, {N{1'b0}}};
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result      = result_reg;
    assign bus.done        = done_reg;
    assign bus.busy        = busy_reg;
    assign bus.zero        = zero_reg;
    assign bus.overflow    = overflow_reg;
    assign bus.underflow   = underflow_reg;
    assign bus.NAN         = nan_reg;
    assign bus.div_by_zero = div0_reg;
endmodule

// File: tb/tb_fp_div.sv
// Directed bench for fp_div: normal quotients, special operands, range limits,
// restart, async reset and enable stalls, all against hand-computed values.
module tb_fp_div;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    fp_div_if #(.N(31)) bus ();

    fp_div dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] flags();
        return {bus.zero, bus.overflow, bus.underflow, bus.NAN, bus.div_by_zero};
    endfunction

    task automatic do_load(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.A    = a;
        bus.B    = b;
        bus.load = 1'b1;
        @(posedge clk);
        #1;
        bus.load = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!bus.done && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        $display("txn %h / %h -> %h flags=%b cycles=%0d", bus.A, bus.B, bus.result, flags(), cyc);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (bus.result !== 32'h0 || bus.done !== 1'b0 || bus.busy !== 1'b0 || flags() !== 5'b0) begin
            bad++;
            $display("FAIL reset: result=%h done=%b busy=%b flags=%b, need all 0",
                     bus.result, bus.done, bus.busy, flags());
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_normal(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_r,
                               input logic [4:0] exp_f);
        int cyc;
        do_load(a, b);
        total++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL busy_after_load: busy=%b done=%b, need 1 0", bus.busy, bus.done);
        end
        wait_done(cyc);
        total++;
        if (cyc !== 26) begin
            bad++;
            $display("FAIL latency %h/%h: got %0d need 26", a, b, cyc);
        end
        total++;
        if (bus.result !== exp_r || flags() !== exp_f || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL quotient %h/%h: got %h flags=%b busy=%b need %h flags=%b busy=0",
                     a, b, bus.result, flags(), bus.busy, exp_r, exp_f);
        end
    endtask

    task automatic test_special(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_r,
                                input logic [4:0] exp_f);
        int cyc;
        do_load(a, b);
        wait_done(cyc);
        total++;
        if (cyc !== 1 || bus.result !== exp_r || flags() !== exp_f || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL special %h/%h: got %h flags=%b cyc=%0d need %h flags=%b cyc=1",
                     a, b, bus.result, flags(), cyc, exp_r, exp_f);
        end
    endtask

    task automatic test_hold();
        logic [31:0] held;
        held = bus.result;
        bus.enable = 1'b0;
        bus.load   = 1'b1;
        bus.A      = 32'h40000000;
        bus.B      = 32'h3F800000;
        repeat (3) @(posedge clk);
        #1;
        bus.load   = 1'b0;
        bus.enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (bus.done !== 1'b1 || bus.result !== held) begin
            bad++;
            $display("FAIL hold_ignore_load: done=%b result=%h need 1 %h", bus.done, bus.result, held);
        end
    endtask

    task automatic test_restart();
        int cyc;
        do_load(32'h40C00000, 32'h40000000);
        repeat (9) @(posedge clk);
        do_load(32'h41200000, 32'h40A00000);
        wait_done(cyc);
        total++;
        if (cyc !== 26 || bus.result !== 32'h40000000 || flags() !== 5'b0) begin
            bad++;
            $display("FAIL restart: got %h cyc=%0d flags=%b need 40000000 cyc=26 flags=0",
                     bus.result, cyc, flags());
        end
    endtask

    task automatic test_async_reset();
        do_load(32'h40C00000, 32'h40000000);
        repeat (11) @(posedge clk);
        #1;
        total++;
        if (bus.busy !== 1'b1 || bus.result === 32'h0) begin
            bad++;
            $display("FAIL pre_reset: busy=%b result=%h need busy=1 and held nonzero result",
                     bus.busy, bus.result);
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        total++;
        if (bus.result !== 32'h0 || bus.done !== 1'b0 || bus.busy !== 1'b0 || flags() !== 5'b0) begin
            bad++;
            $display("FAIL async_reset: result=%h done=%b busy=%b flags=%b, need all 0",
                     bus.result, bus.done, bus.busy, flags());
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_enable_stall();
        int cyc;
        do_load(32'h40C00000, 32'h40000000);
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        bus.enable = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.enable = 1'b1;
        wait_done(cyc);
        total++;
        if (cyc + 13 !== 31 || bus.result !== 32'h40400000) begin
            bad++;
            $display("FAIL enable_stall: got %h after %0d cycles need 40400000 after 31",
                     bus.result, cyc + 13);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int both;
        both = 0;
        do_load(32'h3F800000, 32'h40400000);
        cyc = 0;
        while (!bus.done && cyc < 100) begin
            if (bus.done && bus.busy) both++;
            @(posedge clk);
            #1;
            cyc++;
        end
        do_load(32'h40C00000, 32'h40000000);
        total++;
        if (bus.done !== 1'b0) begin
            bad++;
            $display("FAIL done_clear_on_load: done=%b need 0", bus.done);
        end
        while (!bus.done && cyc < 200) begin
            if (bus.done && bus.busy) both++;
            @(posedge clk);
            #1;
            cyc++;
        end
        total++;
        if (both !== 0 || bus.result !== 32'h40400000) begin
            bad++;
            $display("FAIL back_to_back: overlap=%0d result=%h need 0 40400000", both, bus.result);
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        bus.enable = 1'b1;
        bus.load   = 1'b0;
        bus.A      = '0;
        bus.B      = '0;
        test_reset();
        test_normal(32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000);
        test_normal(32'hBFC00000, 32'h3F000000, 32'hC0400000, 5'b00000);
        test_normal(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 5'b00000);
        test_normal(32'h7F000000, 32'h3E800000, 32'h7F800000, 5'b01000);
        test_normal(32'h00800000, 32'h40000000, 32'h00000000, 5'b10100);
        test_special(32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01001);
        test_special(32'h00000000, 32'h00000000, 32'h7FC00000, 5'b00010);
        test_special(32'h7F800000, 32'h7F800000, 32'h7FC00000, 5'b00010);
        test_special(32'h7FC00001, 32'h40000000, 32'h7FC00000, 5'b00010);
        test_special(32'hFF800000, 32'h40000000, 32'hFF800000, 5'b01000);
        test_special(32'h40000000, 32'hFF800000, 32'h80000000, 5'b10000);
        test_special(32'h00000000, 32'h40000000, 32'h00000000, 5'b10000);
        test_hold();
        test_restart();
        test_async_reset();
        test_enable_stall();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
